sweep_phase_accumulator: RTL and testbench

// - Parametrised NCO phase accumulator with a built-in linear frequency sweep engine for the impedance analyzer.
// - Steps the frequency control word (FCW) through NUM points. Each point holds for a programmable dwell time.
// - Pulses point_valid at the end of each dwell so downstream DFT/capture logic knows when a point is complete.
// - Drives the sine LUT / DAC path and the reference phase of the demodulator.

---
 rtl/sweep_phase_accumulator.sv | 141 ++++++++++++++
 tb/tb_sweep_phase_accumulator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_phase_accumulator.sv
// NCO phase accumulator with a linear FCW sweep engine (NUM points, programmable dwell).
// Optional +90 degree output phase_out_q is enabled by defining QUADRATURE_OUT_EN.
module sweep_phase_accumulator #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16,
    parameter int DWL_W = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [ACC_W-1:0] fcw_start,
    input  logic [ACC_W-1:0] fcw_step,
    input  logic [CNT_W-1:0] num_points,
    input  logic [DWL_W-1:0] dwell_cycles,
    input  logic [OUT_W-1:0] phase_offset,
    output logic [OUT_W-1:0] phase_out,
    output logic [ACC_W-1:0] fcw_active,
    output logic             busy,
    output logic             point_valid,
    output logic [CNT_W-1:0] point_index,
    output logic             done
`ifdef QUADRATURE_OUT_EN
    ,
    output logic [OUT_W-1:0] phase_out_q
`endif
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DWELL = 1'b1;

    function automatic logic [CNT_W-1:0] cnt_at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [DWL_W-1:0] dwl_at_least_one(input logic [DWL_W-1:0] v);
        return (v == '0) ? DWL_W'(1) : v;
    endfunction

    function automatic logic [OUT_W-1:0] phase_wrap_add(input logic [OUT_W-1:0] a,
                                                        input logic [OUT_W-1:0] b);
        return a + b;
    endfunction

    logic             state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fcw_q, fcw_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [DWL_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] npts_q, npts_d;
    logic [DWL_W-1:0] dwell_q, dwell_d;

    logic last_cyc;
    logic last_pt;
    logic take_start;

    assign last_cyc   = (cnt_q == dwell_q - DWL_W'(1));
    assign last_pt    = (idx_q == npts_q - CNT_W'(1));
    assign take_start = (state_q == ST_IDLE) && start && !abort;

    // Point-complete strobes are suppressed combinationally by abort (and reset).
    assign busy        = (state_q == ST_DWELL);
    assign point_valid = busy && last_cyc && !abort && !rst;
    assign done        = point_valid && last_pt;
    assign fcw_active  = fcw_q;
    assign point_index = idx_q;
    assign phase_out   = phase_wrap_add(acc_q[ACC_W-1 -: OUT_W], phase_offset);

`ifdef QUADRATURE_OUT_EN
    localparam logic [OUT_W-1:0] QUARTER_TURN = {2'b01, {(OUT_W-2){1'b0}}};
    assign phase_out_q = phase_wrap_add(phase_out, QUARTER_TURN);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q + fcw_q;
        fcw_d   = fcw_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        npts_d  = npts_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_IDLE: begin
                if (take_start) begin
                    step_d  = fcw_step;
                    npts_d  = cnt_at_least_one(num_points);
                    dwell_d = dwl_at_least_one(dwell_cycles);
                    fcw_d   = fcw_start;
                    acc_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_cyc) begin
                    // Final point keeps its FCW so the tone continues in IDLE.
                    if (last_pt) begin
                        state_d = ST_IDLE;
                    end else begin
                        fcw_d = fcw_q + step_q;
                        idx_d = idx_q + CNT_W'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DWL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            fcw_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fcw_q   <= fcw_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched sweep parameters are only consulted in DWELL, so they need no reset.
    always_ff @(posedge clock) begin
        step_q  <= step_d;
        npts_q  <= npts_d;
        dwell_q <= dwell_d;
    end

endmodule

// File: tb/tb_sweep_phase_accumulator.sv
// Bench for sweep_phase_accumulator: sweep-schedule model checked every cycle plus directed literals.
// Define QUADRATURE_OUT_EN to also check phase_out_q.
module tb_sweep_phase_accumulator;

    localparam int ACC_W = 48;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;
    localparam int DWL_W = 32;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [ACC_W-1:0] fcw_start;
    logic [ACC_W-1:0] fcw_step;
    logic [CNT_W-1:0] num_points;
    logic [DWL_W-1:0] dwell_cycles;
    logic [OUT_W-1:0] phase_offset;
    logic [OUT_W-1:0] phase_out;
    logic [ACC_W-1:0] fcw_active;
    logic             busy;
    logic             point_valid;
    logic [CNT_W-1:0] point_index;
    logic             done;
`ifdef QUADRATURE_OUT_EN
    logic [OUT_W-1:0] phase_out_q;
`endif

    always #5 clock = ~clock;

    sweep_phase_accumulator #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .DWL_W(DWL_W)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .fcw_start    (fcw_start),
        .fcw_step     (fcw_step),
        .num_points   (num_points),
        .dwell_cycles (dwell_cycles),
        .phase_offset (phase_offset),
        .phase_out    (phase_out),
        .fcw_active   (fcw_active),
        .busy         (busy),
        .point_valid  (point_valid),
        .point_index  (point_index),
        .done         (done)
`ifdef QUADRATURE_OUT_EN
        ,
        .phase_out_q  (phase_out_q)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is a schedule; elapsed cycle t maps to point t/dwell at offset t%dwell.
    bit               m_active = 1'b0;
    int               m_t      = 0;
    int               m_np     = 1;
    int               m_dw     = 1;
    logic [ACC_W-1:0] m_fs;
    logic [ACC_W-1:0] m_step;
    logic [ACC_W-1:0] m_acc;
    logic [ACC_W-1:0] m_fcw_hold;
    logic [CNT_W-1:0] m_idx_hold;

    int               k;
    int               pos;
    logic [ACC_W-1:0] exp_fcw;
    logic [CNT_W-1:0] exp_idx;
    logic             exp_busy;
    logic             exp_pv;
    logic             exp_done;
    logic [OUT_W-1:0] exp_phase;

    always_comb begin
        k         = m_t / m_dw;
        pos       = m_t % m_dw;
        exp_fcw   = m_fcw_hold;
        exp_idx   = m_idx_hold;
        exp_busy  = 1'b0;
        exp_pv    = 1'b0;
        exp_done  = 1'b0;
        if (m_active) begin
            exp_fcw  = m_fs + ACC_W'(k) * m_step;
            exp_idx  = CNT_W'(k);
            exp_busy = 1'b1;
            exp_pv   = (pos == m_dw - 1) && !abort && !rst;
            exp_done = exp_pv && (k == m_np - 1);
        end
        exp_phase = m_acc[ACC_W-1 -: OUT_W] + phase_offset;
    end

    always @(posedge clock) begin
        if (rst) begin
            m_active   <= 1'b0;
            m_t        <= 0;
            m_acc      <= '0;
            m_fcw_hold <= '0;
            m_idx_hold <= '0;
        end else begin
            m_acc <= (!m_active && start && !abort) ? '0 : m_acc + exp_fcw;
            if (m_active) begin
                if (abort || exp_done) begin
                    m_active   <= 1'b0;
                    m_fcw_hold <= exp_fcw;
                    m_idx_hold <= exp_idx;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (start && !abort) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_fs     <= fcw_start;
                m_step   <= fcw_step;
                m_np     <= (num_points == '0) ? 1 : int'(num_points);
                m_dw     <= (dwell_cycles == '0) ? 1 : int'(dwell_cycles);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_phase", 64'(phase_out), 64'(exp_phase));
            chk("m_fcw", 64'(fcw_active), 64'(exp_fcw));
            chk("m_idx", 64'(point_index), 64'(exp_idx));
            chk("m_busy", 64'(busy), 64'(exp_busy));
            chk("m_pv", 64'(point_valid), 64'(exp_pv));
            chk("m_done", 64'(done), 64'(exp_done));
`ifdef QUADRATURE_OUT_EN
            chk("m_quad_diff", 64'(OUT_W'(phase_out_q - phase_out)), 64'h4000);
            chk("m_quad", 64'(phase_out_q), 64'(OUT_W'(exp_phase + 16'h4000)));
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input logic [ACC_W-1:0] fs, input logic [ACC_W-1:0] st,
                         input logic [CNT_W-1:0] np, input logic [DWL_W-1:0] dw);
        fcw_start    = fs;
        fcw_step     = st;
        num_points   = np;
        dwell_cycles = dw;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    localparam logic [ACC_W-1:0] ONE32 = 48'h0001_0000_0000;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        phase_offset = 16'h1000;
        setup('0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_phase", 64'(phase_out), 64'h1000);
        chk("rst_fcw", 64'(fcw_active), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pv", 64'(point_valid), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
`ifdef QUADRATURE_OUT_EN
        chk("rst_quad", 64'(phase_out_q), 64'h5000);
`endif
        tick();

        // Basic sweep: 3 points x 4 cycles
        setup(ONE32, ONE32, 16'd3, 32'd4);
        pulse_start();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            chk("bs_busy", 64'(busy), 64'(c <= 12));
            chk("bs_pv", 64'(point_valid), 64'(c == 4 || c == 8 || c == 12));
            chk("bs_done", 64'(done), 64'(c == 12));
            if (c == 1)  chk("bs_fcw0", 64'(fcw_active), 64'h0001_0000_0000);
            if (c == 5)  chk("bs_fcw1", 64'(fcw_active), 64'h0002_0000_0000);
            if (c == 12) chk("bs_fcw2", 64'(fcw_active), 64'h0003_0000_0000);
            if (c == 13) chk("bs_fcw_hold", 64'(fcw_active), 64'h0003_0000_0000);
            if (c == 4)  chk("bs_idx0", 64'(point_index), 64'd0);
            if (c == 8)  chk("bs_idx1", 64'(point_index), 64'd1);
            if (c == 12) chk("bs_idx2", 64'(point_index), 64'd2);
            if (c == 1)  chk("bs_ph1", 64'(phase_out), 64'h1000);
            if (c == 2)  chk("bs_ph2", 64'(phase_out), 64'h1001);
            if (c == 6)  chk("bs_ph6", 64'(phase_out), 64'h1006);
            if (c == 10) chk("bs_ph10", 64'(phase_out), 64'h100F);
            if (c == 13) chk("bs_ph13", 64'(phase_out), 64'h1018);
            tick();
        end

        // Degenerate: zero points and zero dwell become one single-cycle point
        setup(48'h0007_0000_0000, ONE32, 16'd0, 32'd0);
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            chk("dg_busy", 64'(busy), 64'(c == 1));
            chk("dg_pv", 64'(point_valid), 64'(c == 1));
            chk("dg_done", 64'(done), 64'(c == 1));
            if (c == 2) chk("dg_fcw", 64'(fcw_active), 64'h0007_0000_0000);
            tick();
        end

        // Wrap: all-ones FCW plus step 2 wraps to 1
        phase_offset = 16'h1000;
        setup(48'hFFFF_FFFF_FFFF, 48'd2, 16'd2, 32'd3);
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 2) chk("wr_ph2", 64'(phase_out), 64'h0FFF);
            if (c == 4) chk("wr_fcw", 64'(fcw_active), 64'h1);
            chk("wr_done", 64'(done), 64'(c == 6));
            if (c == 7) chk("wr_busy", 64'(busy), 64'h0);
            tick();
        end

        // Abort on cycle 2 of point 1
        phase_offset = 16'h0123;
        setup(ONE32, ONE32, 16'd3, 32'd4);
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            abort = (c == 6);
            @(negedge clock);
            chk("ab_done", 64'(done), 64'h0);
            if (c == 6) chk("ab_pv", 64'(point_valid), 64'h0);
            if (c == 7) begin
                chk("ab_busy", 64'(busy), 64'h0);
                chk("ab_fcw", 64'(fcw_active), 64'h0002_0000_0000);
                chk("ab_idx", 64'(point_index), 64'd1);
            end
            tick();
        end

        // Start during DWELL with changed parameters is ignored
        setup(ONE32, ONE32, 16'd2, 32'd3);
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            start = (c == 2);
            if (c == 2) setup(48'h0005_0000_0000, 48'd0, 16'd9, 32'd9);
            @(negedge clock);
            if (c == 3) chk("sd_fcw", 64'(fcw_active), 64'h0001_0000_0000);
            chk("sd_done", 64'(done), 64'(c == 6));
            if (c == 7) begin
                chk("sd_busy", 64'(busy), 64'h0);
                chk("sd_fcw_end", 64'(fcw_active), 64'h0002_0000_0000);
            end
            tick();
        end
        start = 1'b0;

        // Abort on the final point's last cycle suppresses both strobes
        setup(48'h0009_0000_0000, ONE32, 16'd1, 32'd2);
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            abort = (c == 2);
            @(negedge clock);
            if (c == 2) begin
                chk("af_pv", 64'(point_valid), 64'h0);
                chk("af_done", 64'(done), 64'h0);
            end
            if (c == 3) chk("af_busy", 64'(busy), 64'h0);
            tick();
        end

        // Start together with abort in IDLE starts nothing
        setup(48'h000A_0000_0000, ONE32, 16'd2, 32'd2);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            chk("sa_busy", 64'(busy), 64'h0);
            chk("sa_fcw", 64'(fcw_active), 64'h0009_0000_0000);
            tick();
        end

        // Reset in the middle of a sweep
        setup(ONE32, ONE32, 16'd3, 32'd4);
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            rst = (c == 3);
            @(negedge clock);
            chk("mr_done", 64'(done), 64'h0);
            if (c == 4) begin
                chk("mr_busy", 64'(busy), 64'h0);
                chk("mr_fcw", 64'(fcw_active), 64'h0);
                chk("mr_idx", 64'(point_index), 64'd0);
                chk("mr_phase", 64'(phase_out), 64'h0123);
            end
            tick();
        end
        rst = 1'b0;

        repeat (3) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
